// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the two-client DDR3 app-port arbiter.
// Widths match the MIG user interface.
package ddr3_arb_pkg;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 512;
    localparam int MASK_W = 64;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } arb_state_e;
endpackage

// File: rtl/ddr3_app_arbiter_if.sv
// MIG application port: command, write-data and read-return channels.
// master = arbiter side, slave = MIG side.
interface ddr3_app_arbiter_if;
    import ddr3_arb_pkg::*;

    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [DATA_W-1:0] app_wdf_data;
    logic [MASK_W-1:0] app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask,
        output app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask,
        input  app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/ddr3_arb_tag_fifo.sv
// 1-bit client-ID FIFO: records which client owns each in-flight read.
// Pointers wrap naturally because the depth is a power of two.
module ddr3_arb_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int TAG_DEPTH = 16
) (
    input  logic ui_clk,
    input  logic ui_rst_n,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic pop_tag,
    output logic empty,
    output logic full
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(TAG_DEPTH);

    logic [TAG_DEPTH-1:0] mem;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          cnt;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == DEPTH_C);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_tag = mem[rd_ptr];

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/ddr3_app_arbiter.sv
// Round-robin arbiter sharing one MIG app port between two clients,
// holding one request at a time and routing read data back by tag.
module ddr3_app_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int TAG_DEPTH = 16
) (
    input  logic              ui_clk,
    input  logic              ui_rst_n,
    input  logic              init_calib_complete,
    input  logic              c0_req_valid,
    output logic              c0_req_ready,
    input  logic              c0_req_write,
    input  logic [ADDR_W-1:0] c0_req_addr,
    input  logic [DATA_W-1:0] c0_req_wdata,
    input  logic [MASK_W-1:0] c0_req_wmask,
    output logic              c0_rsp_valid,
    output logic [DATA_W-1:0] c0_rsp_data,
    input  logic              c1_req_valid,
    output logic              c1_req_ready,
    input  logic              c1_req_write,
    input  logic [ADDR_W-1:0] c1_req_addr,
    input  logic [DATA_W-1:0] c1_req_wdata,
    input  logic [MASK_W-1:0] c1_req_wmask,
    output logic              c1_rsp_valid,
    output logic [DATA_W-1:0] c1_rsp_data,
    ddr3_app_arbiter_if.master app,
    output logic              err_underflow
);
    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

    arb_state_e        state, state_nx;
    logic              last_grant;
    logic              grant, pick, room;
    logic              elig0, elig1;
    logic [CW-1:0]     out_cnt;
    logic              lat_write, cmd_done, wdf_done;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [MASK_W-1:0] lat_wmask;
    logic              issue_en, issue_wr;
    logic              cmd_hs, wdf_hs;
    logic              push, pop;
    logic              fifo_empty, fifo_full, tag_out;
    logic              rsp0_q, rsp1_q, underflow_q;
    logic [DATA_W-1:0] rsp_data_q;

    assign room  = (out_cnt < DEPTH_C) & ~fifo_full;
    assign elig0 = c0_req_valid & init_calib_complete & (c0_req_write | room);
    assign elig1 = c1_req_valid & init_calib_complete & (c1_req_write | room);

    assign issue_en = (state == ST_ISSUE) & ~cmd_done;
    assign issue_wr = (state == ST_ISSUE) & lat_write & ~wdf_done;
    assign cmd_hs   = issue_en & app.app_rdy;
    assign wdf_hs   = issue_wr & app.app_wdf_rdy;

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        pick     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                grant = ui_rst_n & (elig0 | elig1);
                pick  = (elig0 & elig1) ? ~last_grant : elig1;
                if (grant) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                if ((cmd_done | cmd_hs) &
                    (~lat_write | wdf_done | wdf_hs))
                    state_nx = ST_IDLE;
            end
        endcase
    end

    assign c0_req_ready = grant & ~pick;
    assign c1_req_ready = grant & pick;

    assign app.app_en       = issue_en;
    assign app.app_cmd      = ((state == ST_ISSUE) && !lat_write)
                              ? APP_CMD_READ : APP_CMD_WRITE;
    assign app.app_addr     = lat_addr;
    assign app.app_wdf_data = lat_wdata;
    assign app.app_wdf_mask = lat_wmask;
    assign app.app_wdf_wren = issue_wr;
    assign app.app_wdf_end  = issue_wr;

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
            cmd_done   <= 1'b0;
            wdf_done   <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                last_grant <= pick;
                lat_write  <= pick ? c1_req_write : c0_req_write;
                lat_addr   <= pick ? c1_req_addr  : c0_req_addr;
                lat_wdata  <= pick ? c1_req_wdata : c0_req_wdata;
                lat_wmask  <= pick ? c1_req_wmask : c0_req_wmask;
                cmd_done   <= 1'b0;
                wdf_done   <= 1'b0;
            end else begin
                if (cmd_hs) cmd_done <= 1'b1;
                if (wdf_hs) wdf_done <= 1'b1;
            end
        end
    end

    // Tag is pushed at grant time so returns always find their owner.
    assign push = grant & ~(pick ? c1_req_write : c0_req_write);
    assign pop  = app.app_rd_data_valid & ~fifo_empty;

    ddr3_arb_tag_fifo #(.TAG_DEPTH(TAG_DEPTH)) u_tag_fifo (
        .ui_clk   (ui_clk),
        .ui_rst_n (ui_rst_n),
        .push     (push),
        .push_tag (pick),
        .pop      (pop),
        .pop_tag  (tag_out),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            out_cnt     <= '0;
            rsp0_q      <= 1'b0;
            rsp1_q      <= 1'b0;
            rsp_data_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            rsp0_q <= pop & ~tag_out;
            rsp1_q <= pop & tag_out;
            if (pop) rsp_data_q <= app.app_rd_data;
            if (app.app_rd_data_valid && fifo_empty)
                underflow_q <= 1'b1;
        end
    end

    assign c0_rsp_valid  = rsp0_q;
    assign c1_rsp_valid  = rsp1_q;
    assign c0_rsp_data   = rsp_data_q;
    assign c1_rsp_data   = rsp_data_q;
    assign err_underflow = underflow_q;
endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed bench for ddr3_app_arbiter: per-cycle vector table plus
// hand-written sequences for stalls, tag-full blocking and reset.
module tb_ddr3_app_arbiter;
    import ddr3_arb_pkg::*;

    typedef struct {
        logic [7:0]  in;
        logic [10:0] exp;
    } vec_t;

    localparam int NV = 32;

    logic              ui_clk = 1'b0;
    logic              ui_rst_n;
    logic              init_calib_complete;
    logic              c0_req_valid, c0_req_ready, c0_req_write;
    logic [ADDR_W-1:0] c0_req_addr;
    logic [DATA_W-1:0] c0_req_wdata;
    logic [MASK_W-1:0] c0_req_wmask;
    logic              c0_rsp_valid;
    logic [DATA_W-1:0] c0_rsp_data;
    logic              c1_req_valid, c1_req_ready, c1_req_write;
    logic [ADDR_W-1:0] c1_req_addr;
    logic [DATA_W-1:0] c1_req_wdata;
    logic [MASK_W-1:0] c1_req_wmask;
    logic              c1_rsp_valid;
    logic [DATA_W-1:0] c1_rsp_data;
    logic              err_underflow;

    ddr3_app_arbiter_if app_bus ();

    ddr3_app_arbiter #(.TAG_DEPTH(4)) dut (
        .ui_clk              (ui_clk),
        .ui_rst_n            (ui_rst_n),
        .init_calib_complete (init_calib_complete),
        .c0_req_valid        (c0_req_valid),
        .c0_req_ready        (c0_req_ready),
        .c0_req_write        (c0_req_write),
        .c0_req_addr         (c0_req_addr),
        .c0_req_wdata        (c0_req_wdata),
        .c0_req_wmask        (c0_req_wmask),
        .c0_rsp_valid        (c0_rsp_valid),
        .c0_rsp_data         (c0_rsp_data),
        .c1_req_valid        (c1_req_valid),
        .c1_req_ready        (c1_req_ready),
        .c1_req_write        (c1_req_write),
        .c1_req_addr         (c1_req_addr),
        .c1_req_wdata        (c1_req_wdata),
        .c1_req_wmask        (c1_req_wmask),
        .c1_rsp_valid        (c1_rsp_valid),
        .c1_rsp_data         (c1_rsp_data),
        .app                 (app_bus),
        .err_underflow       (err_underflow)
    );

    always #5 ui_clk = ~ui_clk;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vt [NV];

    task automatic check(input string name, input logic [511:0] act,
                         input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ui_clk);
        #1;
    endtask

    // {c0v,c0w, c1v,c1w, calib, app_rdy,wdf_rdy, rd_valid}
    task automatic apply(input logic [7:0] v);
        {c0_req_valid, c0_req_write, c1_req_valid, c1_req_write,
         init_calib_complete, app_bus.app_rdy, app_bus.app_wdf_rdy,
         app_bus.app_rd_data_valid} = v;
    endtask

    // {rdy0,rdy1, en,wren,wend, cmd, rsp0,rsp1, err}
    function automatic logic [10:0] outv();
        return {c0_req_ready, c1_req_ready, app_bus.app_en,
                app_bus.app_wdf_wren, app_bus.app_wdf_end,
                app_bus.app_cmd, c0_rsp_valid, c1_rsp_valid,
                err_underflow};
    endfunction

    initial begin
        logic [DATA_W-1:0] pat, pat2, cap_d;
        logic [MASK_W-1:0] cap_m;
        logic [2:0]        cap_cmd;
        int                en_cnt, wr_cnt, addr_bad;

        pat  = {16{32'hA5A5_1234}};
        pat2 = {16{32'h5A5A_C0DE}};

        vt[0]  = '{8'b11_00_0_00_0, 11'b00_000_000_00_0};
        vt[1]  = '{8'b10_10_1_10_0, 11'b10_000_000_00_0};
        vt[2]  = '{8'b10_10_1_10_0, 11'b00_100_001_00_0};
        vt[3]  = '{8'b10_10_1_10_0, 11'b01_000_000_00_0};
        vt[4]  = '{8'b10_10_1_10_0, 11'b00_100_001_00_0};
        vt[5]  = '{8'b10_10_1_10_1, 11'b10_000_000_00_0};
        vt[6]  = '{8'b00_00_1_10_1, 11'b00_100_001_10_0};
        vt[7]  = '{8'b00_00_1_10_1, 11'b00_000_000_01_0};
        vt[8]  = '{8'b00_00_1_10_0, 11'b00_000_000_10_0};
        vt[9]  = '{8'b11_00_1_11_0, 11'b10_000_000_00_0};
        vt[10] = '{8'b00_00_1_11_0, 11'b00_111_000_00_0};
        vt[11] = '{8'b00_00_1_11_0, 11'b00_000_000_00_0};
        vt[12] = '{8'b00_11_1_01_0, 11'b01_000_000_00_0};
        vt[13] = '{8'b00_00_1_01_0, 11'b00_111_000_00_0};
        vt[14] = '{8'b00_00_1_01_0, 11'b00_100_000_00_0};
        vt[15] = '{8'b00_00_1_11_0, 11'b00_100_000_00_0};
        vt[16] = '{8'b00_00_1_11_0, 11'b00_000_000_00_0};
        vt[17] = '{8'b11_00_1_10_0, 11'b10_000_000_00_0};
        vt[18] = '{8'b00_00_1_10_0, 11'b00_111_000_00_0};
        vt[19] = '{8'b00_00_1_10_0, 11'b00_011_000_00_0};
        vt[20] = '{8'b00_00_1_11_0, 11'b00_011_000_00_0};
        vt[21] = '{8'b00_00_1_11_0, 11'b00_000_000_00_0};
        vt[22] = '{8'b00_10_1_00_0, 11'b01_000_000_00_0};
        vt[23] = '{8'b11_00_0_00_0, 11'b00_100_001_00_0};
        vt[24] = '{8'b11_00_0_10_0, 11'b00_100_001_00_0};
        vt[25] = '{8'b11_00_0_10_0, 11'b00_000_000_00_0};
        vt[26] = '{8'b00_00_0_00_1, 11'b00_000_000_00_0};
        vt[27] = '{8'b00_00_0_00_0, 11'b00_000_000_01_0};
        vt[28] = '{8'b00_00_0_00_1, 11'b00_000_000_00_0};
        vt[29] = '{8'b00_00_0_00_0, 11'b00_000_000_00_1};
        vt[30] = '{8'b00_00_1_11_1, 11'b00_000_000_00_1};
        vt[31] = '{8'b00_00_0_00_0, 11'b00_000_000_00_1};

        ui_rst_n     = 1'b0;
        c0_req_addr  = 28'h0AB;
        c1_req_addr  = 28'h0CD;
        c0_req_wdata = pat;
        c1_req_wdata = pat2;
        c0_req_wmask = '0;
        c1_req_wmask = '1;
        app_bus.app_rd_data = pat2;
        apply(8'b11_00_1_11_0);

        #12;
        check("reset_outs", 512'(outv()), 512'd0);
        check("reset_addr", 512'(app_bus.app_addr), 512'd0);
        check("reset_wdata", app_bus.app_wdf_data, 512'd0);
        check("reset_rspdata", c0_rsp_data, 512'd0);
        apply(8'b0);
        step();
        ui_rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(vt[i].in);
            #2;
            check($sformatf("vec%0d", i), 512'(outv()), 512'(vt[i].exp));
            step();
        end

        apply(8'b0);
        #2;
        check("underflow_sticky", 512'(err_underflow), 512'd1);
        ui_rst_n = 1'b0;
        #1;
        check("underflow_clear", 512'(err_underflow), 512'd0);
        step();
        step();
        ui_rst_n = 1'b1;

        // Write stalled on the command channel for five cycles
        c0_req_addr  = 28'h10;
        c0_req_wdata = pat;
        c0_req_wmask = 64'h00FF;
        apply(8'b11_00_1_01_0);
        #2;
        check("stall_grant", 512'(c0_req_ready), 512'd1);
        step();
        c0_req_valid = 1'b0;
        c0_req_addr  = 28'h3FF;
        en_cnt = 0;
        wr_cnt = 0;
        addr_bad = 0;
        cap_d = '0;
        cap_m = '0;
        cap_cmd = 3'b111;
        for (int k = 0; k < 20; k++) begin
            app_bus.app_rdy = (k == 5);
            #2;
            if (k == 0) begin
                cap_d   = app_bus.app_wdf_data;
                cap_m   = app_bus.app_wdf_mask;
                cap_cmd = app_bus.app_cmd;
            end
            if (!app_bus.app_en) break;
            en_cnt++;
            if (app_bus.app_addr != 28'h10) addr_bad++;
            if (app_bus.app_wdf_wren) wr_cnt++;
            step();
        end
        check("stall_en_cycles", 512'(en_cnt), 512'd6);
        check("stall_wdf_once", 512'(wr_cnt), 512'd1);
        check("stall_addr_stable", 512'(addr_bad), 512'd0);
        check("stall_wdata", cap_d, pat);
        check("stall_wmask", 512'(cap_m), 512'h00FF);
        check("stall_cmd", 512'(cap_cmd), 512'd0);
        step();

        // Fill all four tags with client-0 reads
        for (int k = 0; k < 4; k++) begin
            apply(8'b10_00_1_11_0);
            #2;
            check($sformatf("fill_grant%0d", k), 512'(c0_req_ready), 512'd1);
            step();
            c0_req_valid = 1'b0;
            step();
        end
        apply(8'b10_11_1_11_0);
        #2;
        check("full_c0_blocked", 512'(c0_req_ready), 512'd0);
        check("full_c1_write", 512'(c1_req_ready), 512'd1);
        step();
        c1_req_valid = 1'b0;
        step();
        #2;
        check("full_c0_still", 512'(c0_req_ready), 512'd0);
        step();
        app_bus.app_rd_data = pat2;
        app_bus.app_rd_data_valid = 1'b1;
        #2;
        check("full_ret_cycle", 512'(c0_req_ready), 512'd0);
        step();
        app_bus.app_rd_data_valid = 1'b0;
        app_bus.app_rdy = 1'b0;
        #2;
        check("freed_c0_grant", 512'(c0_req_ready), 512'd1);
        check("freed_rsp_valid", 512'(c0_rsp_valid), 512'd1);
        check("freed_rsp_data", c0_rsp_data, pat2);
        step();
        c0_req_valid = 1'b0;

        // Reset asserted while a read is waiting in ISSUE
        #2;
        check("issue_before_rst", 512'(app_bus.app_en), 512'd1);
        ui_rst_n = 1'b0;
        #1;
        check("rst_kills_en", 512'(app_bus.app_en), 512'd0);
        step();
        step();
        ui_rst_n = 1'b1;
        apply(8'b10_10_1_10_0);
        #2;
        check("post_rst_c0", 512'(c0_req_ready), 512'd1);
        check("post_rst_c1", 512'(c1_req_ready), 512'd0);
        step();
        apply(8'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
